imp_var_std_unit: RTL and testbench
===================================

IMP_VAR_STD_UNIT -- requirements
Module: imp_var_std_unit

Interface
REQ-001 SHALL have parameter EPS, default 1, meaning the integer epsilon added to variance when IMP_VAR_EPS_EN is defined (range 0..65535).
REQ-002 SHALL have port i_clk, input, 1, system clock; all logic on the rising edge.
REQ-003 SHALL have port i_rstn, input, 1, asynchronous active-low reset.
REQ-004 SHALL have port i_Ex_valid, input, 1, single-cycle strobe qualifying i_Ex (the mean stage's done).
REQ-005 SHALL have port i_Ex, input, 9, signed mean E[x].
REQ-006 SHALL have port i_Ex2_valid, input, 1, single-cycle strobe qualifying i_Ex2 (the Ex2 stage's done).
REQ-007 SHALL have port i_Ex2, input, 16, unsigned mean of squares E[x^2].
REQ-008 SHALL have port o_var, output, 16, unsigned variance, integer.
REQ-009 SHALL have port o_std, output, 16, unsigned standard deviation, Q8.8.
REQ-010 SHALL have port o_done, output, 1, one-cycle pulse marking o_var/o_std as new.
REQ-011 SHALL have port o_busy, output, 1, high in every state except WAIT.
REQ-012 SHALL have port o_neg_clamp, output, 1, high when the last result was clamped from negative.
REQ-013 SHALL have port o_drop, output, 1, sticky flag: a strobe arrived while busy.

Function
REQ-014 SHALL implement states WAIT, VAR, SQRT, DONE.
REQ-015 In WAIT, each strobe SHALL latch its operand and set its have-flag independently, in either order.
REQ-016 A repeated strobe for an already-held operand in WAIT SHALL overwrite it with the newest value.
REQ-017 Simultaneous strobes in WAIT SHALL capture both on the same edge.
REQ-018 WAIT SHALL go to VAR on the edge after which both have-flags are set.
REQ-019 VAR SHALL last one cycle and compute Ex^2 in 17 bits and d = Ex2 - Ex^2 in 18-bit signed.
REQ-020 If d < 0, VAR SHALL set var to 0 and neg_clamp to 1; otherwise var = d[15:0] and neg_clamp = 0.
REQ-021 SQRT SHALL last exactly 16 cycles and perform one restoring-sqrt bit per cycle on radicand {var,16'h0}, giving floor(sqrt(var*65536)) as Q8.8.
REQ-022 DONE SHALL last one cycle, drive o_done = 1, clear the have-flags and return to WAIT.
REQ-023 Latency SHALL be 18 cycles: o_done is high in the 18th cycle after the capturing edge of the last operand.
REQ-024 o_var, o_std and o_neg_clamp SHALL be registered, update on entering DONE, and hold until the next DONE.
REQ-025 Strobes in VAR, SQRT or DONE SHALL be ignored and SHALL set o_drop, which stays set until reset.
REQ-026 No intermediate value SHALL be truncated except as stated; var = 65535 SHALL give o_std = 16'hFFFF.

Reset
REQ-027 Asserting i_rstn low SHALL force WAIT and clear the have-flags, operands, sqrt datapath, o_var, o_std, o_done, o_neg_clamp and o_drop to 0, asynchronously.
REQ-028 A reset mid-SQRT SHALL abandon the computation; no o_done SHALL follow release until two fresh operands arrive.

Configuration
REQ-029 With macro IMP_VAR_EPS_EN defined, VAR SHALL add EPS to var after clamping, saturating at 16'hFFFF; o_var SHALL report the sum.
REQ-030 Without IMP_VAR_EPS_EN, no adder SHALL exist and var SHALL go to SQRT unmodified; EPS SHALL be unused.

Structure
REQ-031 Package imp_ln_pkg SHALL hold the widths EX_W=9, EX2_W=16, VAR_W=16, STD_W=16, the STD_FRAC=8 constant and the state encoding.
REQ-032 The bit-serial restoring square root SHALL be a sub-module imp_isqrt_bitserial with a start/done interface, instantiated once.

Verification
REQ-033 Ex=0 then Ex2=256 two cycles later -> o_var=256, o_std=16'h1000, o_neg_clamp=0, o_done 18 cycles after the Ex2 strobe.
REQ-034 Simultaneous Ex=10, Ex2=164 -> o_var=64, o_std=16'h0800.
REQ-035 Ex=-3, Ex2=11 -> o_var=2, o_std=16'h016A.
REQ-036 Ex=5, Ex2=20 -> o_var=0, o_std=0, o_neg_clamp=1; with IMP_VAR_EPS_EN, EPS=1 -> o_var=1, o_std=16'h0100, o_neg_clamp=1.
REQ-037 Ex=0, Ex2=65535 -> o_std=16'hFFFF; a strobe during SQRT -> o_drop=1 and the result is unchanged.
REQ-038 Reset pulse in SQRT cycle 8 -> all outputs 0, no o_done; next operand pair -> normal result at 18-cycle latency.

Source files
------------

// File: rtl/imp_ln_pkg.sv
// Shared widths, derived datapath widths and FSM state encoding for the
// variance / standard-deviation unit and its bit-serial square root.
package imp_ln_pkg;

  localparam int EX_W     = 9;   // signed mean E[x]
  localparam int EX2_W    = 16;  // unsigned mean of squares E[x^2]
  localparam int VAR_W    = 16;  // integer variance
  localparam int STD_W    = 16;  // standard deviation, Q8.8
  localparam int STD_FRAC = 8;   // fractional bits of the standard deviation

  // |E[x]| <= 256, so its square needs one bit more than twice the magnitude
  localparam int SQ_W     = 2 * (EX_W - 1) + 1;
  // Ex2 - Ex^2 as a signed quantity with headroom for both extremes
  localparam int DIFF_W   = EX2_W + 2;

  typedef enum logic [1:0] {
    ST_WAIT = 2'd0,
    ST_VAR  = 2'd1,
    ST_SQRT = 2'd2,
    ST_DONE = 2'd3
  } state_e;

endpackage

// File: rtl/imp_isqrt_bitserial.sv
// Bit-serial restoring integer square root: root = floor(sqrt(radicand)).
// The first root bit is resolved on the start edge, one further bit per
// cycle after that; done pulses for one cycle once all ROOT_W bits are in.
module imp_isqrt_bitserial #(
  parameter int ROOT_W = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  start,
  input  logic [2*ROOT_W-1:0]   radicand,
  output logic                  done,
  output logic [ROOT_W-1:0]     root
);

  localparam int RAD_W = 2 * ROOT_W;
  localparam int REM_W = ROOT_W + 3;
  localparam int CNT_W = $clog2(ROOT_W);

  logic [REM_W-1:0]  rem_r;
  logic [ROOT_W-1:0] root_r;
  logic [RAD_W-1:0]  rad_r;
  logic [CNT_W-1:0]  cnt_r;
  logic              busy_r;
  logic              done_r;

  // One restoring step: bring down the next radicand bit pair, try (root<<2)|1.
  function automatic logic [REM_W+ROOT_W-1:0] sqrt_step(
    input logic [REM_W-1:0]  rem,
    input logic [ROOT_W-1:0] rt,
    input logic [1:0]        pair
  );
    logic [REM_W-1:0] rem_sh;
    logic [REM_W-1:0] trial;
    rem_sh = (rem << 2) | {{(REM_W-2){1'b0}}, pair};
    trial  = {1'b0, rt, 2'b01};
    if (rem_sh >= trial) begin
      return {rem_sh - trial, rt[ROOT_W-2:0], 1'b1};
    end else begin
      return {rem_sh, rt[ROOT_W-2:0], 1'b0};
    end
  endfunction

  // Iteration registers: load-and-first-step on start, then step while busy.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      rem_r  <= '0;
      root_r <= '0;
      rad_r  <= '0;
      cnt_r  <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else if (start) begin
      {rem_r, root_r} <= sqrt_step('0, '0, radicand[RAD_W-1 -: 2]);
      rad_r  <= radicand << 2;
      cnt_r  <= CNT_W'(ROOT_W - 1);
      busy_r <= 1'b1;
      done_r <= 1'b0;
    end else if (busy_r) begin
      {rem_r, root_r} <= sqrt_step(rem_r, root_r, rad_r[RAD_W-1 -: 2]);
      rad_r <= rad_r << 2;
      cnt_r <= cnt_r - CNT_W'(1);
      if (cnt_r == CNT_W'(1)) begin
        busy_r <= 1'b0;
        done_r <= 1'b1;
      end else begin
        busy_r <= 1'b1;
        done_r <= 1'b0;
      end
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done = done_r;
  assign root = root_r;

endmodule

// File: rtl/imp_var_std_unit.sv
// Variance and standard deviation from E[x] and E[x^2]:
//   var = max(Ex2 - Ex^2, 0), std = floor(sqrt(var * 65536)) in Q8.8.
// Optional feature macro IMP_VAR_EPS_EN: adds EPS to var (saturating)
// before the square root; without it EPS is unused and no adder exists.
module imp_var_std_unit
  import imp_ln_pkg::*;
#(
  parameter int unsigned EPS = 1
) (
  input  logic               i_clk,
  input  logic               i_rstn,
  input  logic               i_Ex_valid,
  input  logic [EX_W-1:0]    i_Ex,
  input  logic               i_Ex2_valid,
  input  logic [EX2_W-1:0]   i_Ex2,
  output logic [VAR_W-1:0]   o_var,
  output logic [STD_W-1:0]   o_std,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_neg_clamp,
  output logic               o_drop
);

  state_e             state_r;
  logic               have_ex_r;
  logic               have_ex2_r;
  logic [EX_W-1:0]    ex_r;
  logic [EX2_W-1:0]   ex2_r;
  logic [VAR_W-1:0]   var_r;
  logic               neg_r;
  logic [VAR_W-1:0]   var_out_r;
  logic [STD_W-1:0]   std_out_r;
  logic               neg_out_r;
  logic               done_out_r;
  logic               drop_r;

  logic [EX_W-1:0]    ex_abs_s;
  logic [SQ_W-1:0]    ex_sq_s;
  logic [DIFF_W-1:0]  diff_s;
  logic [VAR_W-1:0]   var_clamp_s;
  logic [VAR_W-1:0]   var_s;
  logic               neg_s;
  logic               sqrt_start_s;
  logic               sqrt_done_s;
  logic [STD_W-1:0]   root_s;
`ifdef IMP_VAR_EPS_EN
  logic [VAR_W:0]     sum_s;
`endif

  // VAR-stage arithmetic: |Ex|^2, signed difference, clamp (and optional epsilon).
  always_comb begin
    ex_abs_s    = '0;
    ex_sq_s     = '0;
    diff_s      = '0;
    var_clamp_s = '0;
    var_s       = '0;
    neg_s       = 1'b0;
`ifdef IMP_VAR_EPS_EN
    sum_s       = '0;
`endif
    if (ex_r[EX_W-1]) begin
      ex_abs_s = ~ex_r + EX_W'(1);
    end else begin
      ex_abs_s = ex_r;
    end
    ex_sq_s = SQ_W'(ex_abs_s) * SQ_W'(ex_abs_s);
    diff_s  = DIFF_W'(ex2_r) - DIFF_W'(ex_sq_s);
    if (diff_s[DIFF_W-1]) begin
      var_clamp_s = '0;
      neg_s       = 1'b1;
    end else if (diff_s[VAR_W]) begin
      // Unreachable with a 16-bit Ex2; saturate rather than wrap if widths change.
      var_clamp_s = '1;
      neg_s       = 1'b0;
    end else begin
      var_clamp_s = diff_s[VAR_W-1:0];
      neg_s       = 1'b0;
    end
`ifdef IMP_VAR_EPS_EN
    sum_s = {1'b0, var_clamp_s} + (VAR_W+1)'(EPS);
    if (sum_s[VAR_W]) begin
      var_s = '1;
    end else begin
      var_s = sum_s[VAR_W-1:0];
    end
`else
    var_s = var_clamp_s;
`endif
  end

  assign sqrt_start_s = (state_r == ST_VAR);

  imp_isqrt_bitserial #(
    .ROOT_W (STD_W)
  ) u_isqrt (
    .i_clk    (i_clk),
    .i_rstn   (i_rstn),
    .start    (sqrt_start_s),
    .radicand ({var_s, {(2*STD_FRAC){1'b0}}}),
    .done     (sqrt_done_s),
    .root     (root_s)
  );

  // Control FSM: operand capture, VAR/SQRT sequencing, registered results and drop flag.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      state_r    <= ST_WAIT;
      have_ex_r  <= 1'b0;
      have_ex2_r <= 1'b0;
      ex_r       <= '0;
      ex2_r      <= '0;
      var_r      <= '0;
      neg_r      <= 1'b0;
      var_out_r  <= '0;
      std_out_r  <= '0;
      neg_out_r  <= 1'b0;
      done_out_r <= 1'b0;
      drop_r     <= 1'b0;
    end else begin
      done_out_r <= 1'b0;
      case (state_r)
        ST_WAIT: begin
          if (i_Ex_valid) begin
            ex_r      <= i_Ex;
            have_ex_r <= 1'b1;
          end
          if (i_Ex2_valid) begin
            ex2_r      <= i_Ex2;
            have_ex2_r <= 1'b1;
          end
          if ((have_ex_r | i_Ex_valid) & (have_ex2_r | i_Ex2_valid)) begin
            state_r <= ST_VAR;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_VAR: begin
          var_r   <= var_s;
          neg_r   <= neg_s;
          state_r <= ST_SQRT;
        end
        ST_SQRT: begin
          if (sqrt_done_s) begin
            state_r    <= ST_DONE;
            done_out_r <= 1'b1;
            var_out_r  <= var_r;
            std_out_r  <= root_s;
            neg_out_r  <= neg_r;
          end else begin
            state_r <= ST_SQRT;
          end
        end
        ST_DONE: begin
          have_ex_r  <= 1'b0;
          have_ex2_r <= 1'b0;
          state_r    <= ST_WAIT;
        end
        default: begin
          state_r <= ST_WAIT;
        end
      endcase
      if ((state_r != ST_WAIT) && (i_Ex_valid || i_Ex2_valid)) begin
        drop_r <= 1'b1;
      end
    end
  end

  assign o_var       = var_out_r;
  assign o_std       = std_out_r;
  assign o_neg_clamp = neg_out_r;
  assign o_done      = done_out_r;
  assign o_drop      = drop_r;
  assign o_busy      = (state_r != ST_WAIT);

endmodule

// File: tb/tb_imp_var_std_unit.sv
// Scoreboard bench for imp_var_std_unit: expected results are pushed when an
// operand pair completes and popped when o_done is seen (sampled on negedge).
module tb_imp_var_std_unit;

  logic        clk = 1'b0;
  logic        rstn;
  logic        ex_v;
  logic [8:0]  ex_d;
  logic        ex2_v;
  logic [15:0] ex2_d;
  logic [15:0] o_var;
  logic [15:0] o_std;
  logic        o_done;
  logic        o_busy;
  logic        o_neg_clamp;
  logic        o_drop;

  typedef struct {
    logic [15:0] v;
    logic [15:0] s;
    logic        n;
  } exp_t;

  exp_t sb[$];
  int   tests   = 0;
  int   fails   = 0;
  int   cyc     = 0;
  int   cap_cyc = 0;

  always #5 clk = ~clk;

  // Free-running cycle counter used for latency measurement.
  always @(posedge clk) cyc <= cyc + 1;

  imp_var_std_unit #(.EPS(1)) dut (
    .i_clk       (clk),
    .i_rstn      (rstn),
    .i_Ex_valid  (ex_v),
    .i_Ex        (ex_d),
    .i_Ex2_valid (ex2_v),
    .i_Ex2       (ex2_d),
    .o_var       (o_var),
    .o_std       (o_std),
    .o_done      (o_done),
    .o_busy      (o_busy),
    .o_neg_clamp (o_neg_clamp),
    .o_drop      (o_drop)
  );

  // Reference square root by trial squares, independent of the restoring form.
  function automatic longint ref_isqrt(input longint n);
    longint r = 0;
    for (int b = 15; b >= 0; b--) begin
      longint t = r | (longint'(1) << b);
      if (t * t <= n) r = t;
    end
    return r;
  endfunction

  function automatic exp_t model(input int ex_i, input int ex2_i);
    exp_t   e;
    int     d;
    longint r;
    d   = ex2_i - ex_i * ex_i;
    e.n = (d < 0);
    if (d < 0) d = 0;
`ifdef IMP_VAR_EPS_EN
    d = d + 1;
    if (d > 65535) d = 65535;
`endif
    r   = ref_isqrt(longint'(d) * 65536);
    e.v = d[15:0];
    e.s = r[15:0];
    return e;
  endfunction

  task automatic pulse(input logic do_ex, input int ex_i, input logic do_ex2, input int ex2_i);
    @(negedge clk);
    ex_v    = do_ex;
    ex_d    = ex_i[8:0];
    ex2_v   = do_ex2;
    ex2_d   = ex2_i[15:0];
    cap_cyc = cyc;
    @(negedge clk);
    ex_v  = 1'b0;
    ex2_v = 1'b0;
  endtask

  task automatic wait_result(input string name);
    int   n = 0;
    exp_t e;
    while (o_done !== 1'b1 && n < 60) begin
      @(negedge clk);
      n++;
    end
    tests++;
    if (o_done !== 1'b1) begin
      $display("FAIL %s timeout: o_done not seen within 60 cycles", name);
      fails++;
    end else if (sb.size() == 0) begin
      $display("FAIL %s: o_done with empty scoreboard", name);
      fails++;
    end else begin
      e = sb.pop_front();
      tests++;
      if ((cyc - cap_cyc) !== 18) begin
        $display("FAIL %s latency: got %0d want 18", name, cyc - cap_cyc); fails++;
      end
      tests++;
      if (o_var !== e.v) begin
        $display("FAIL %s o_var: got %0d want %0d", name, o_var, e.v); fails++;
      end
      tests++;
      if (o_std !== e.s) begin
        $display("FAIL %s o_std: got %h want %h", name, o_std, e.s); fails++;
      end
      tests++;
      if (o_neg_clamp !== e.n) begin
        $display("FAIL %s o_neg_clamp: got %b want %b", name, o_neg_clamp, e.n); fails++;
      end
      @(negedge clk);
      tests++;
      if (o_done !== 1'b0 || o_var !== e.v || o_std !== e.s) begin
        $display("FAIL %s hold: done=%b var=%0d std=%h want done=0 var=%0d std=%h",
                 name, o_done, o_var, o_std, e.v, e.s);
        fails++;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    tests++;
    if ({o_var, o_std, o_done, o_busy, o_neg_clamp, o_drop} !== 36'd0) begin
      $display("FAIL reset: var=%0d std=%h done=%b busy=%b neg=%b drop=%b want all 0",
               o_var, o_std, o_done, o_busy, o_neg_clamp, o_drop);
      fails++;
    end
    rstn = 1'b1;
  endtask

  task automatic test_split_strobes();
    sb.push_back(model(0, 256));
    pulse(1'b1, 0, 1'b0, 0);
    tests++;
    if (o_busy !== 1'b0) begin
      $display("FAIL one_operand busy: got %b want 0", o_busy); fails++;
    end
    pulse(1'b0, 0, 1'b1, 256);
    wait_result("split_0_256");
  endtask

  task automatic test_simultaneous();
    sb.push_back(model(10, 164));
    pulse(1'b1, 10, 1'b1, 164);
    tests++;
    if (o_busy !== 1'b1) begin
      $display("FAIL simult busy: got %b want 1", o_busy); fails++;
    end
    wait_result("simult_10_164");
    sb.push_back(model(-3, 11));
    pulse(1'b1, -3, 1'b1, 11);
    wait_result("neg_ex_m3_11");
    sb.push_back(model(5, 20));
    pulse(1'b1, 5, 1'b1, 20);
    wait_result("clamp_5_20");
  endtask

  task automatic test_order_overwrite();
    sb.push_back(model(0, 256));
    pulse(1'b1, 7, 1'b0, 0);
    pulse(1'b1, 0, 1'b0, 0);
    pulse(1'b0, 0, 1'b1, 256);
    wait_result("overwrite_ex");
    sb.push_back(model(-6, 100));
    pulse(1'b0, 0, 1'b1, 100);
    pulse(1'b1, -6, 1'b0, 0);
    wait_result("ex2_first");
  endtask

  task automatic test_max_and_drop();
    sb.push_back(model(0, 65535));
    pulse(1'b1, 0, 1'b1, 65535);
    repeat (4) @(negedge clk);
    ex_v = 1'b1; ex_d = 9'd100; ex2_v = 1'b1; ex2_d = 16'd7;
    @(negedge clk);
    ex_v = 1'b0; ex2_v = 1'b0;
    tests++;
    if (o_drop !== 1'b1) begin
      $display("FAIL drop set: got %b want 1", o_drop); fails++;
    end
    wait_result("max_65535");
    tests++;
    if (o_drop !== 1'b1 || o_busy !== 1'b0) begin
      $display("FAIL drop sticky: drop=%b busy=%b want drop=1 busy=0", o_drop, o_busy); fails++;
    end
  endtask

  task automatic test_reset_mid_sqrt();
    int seen = 0;
    pulse(1'b1, 3, 1'b1, 100);
    while ((cyc - cap_cyc) < 9) @(negedge clk);
    rstn = 1'b0;
    #1;
    tests++;
    if ({o_var, o_std, o_done, o_busy, o_neg_clamp, o_drop} !== 36'd0) begin
      $display("FAIL mid_sqrt reset: var=%0d std=%h done=%b busy=%b neg=%b drop=%b want all 0",
               o_var, o_std, o_done, o_busy, o_neg_clamp, o_drop);
      fails++;
    end
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (o_done === 1'b1 || o_busy === 1'b1) seen++;
    end
    tests++;
    if (seen !== 0) begin
      $display("FAIL abandoned: done/busy seen in %0d cycles want 0", seen); fails++;
    end
    sb.push_back(model(-7, 60));
    pulse(1'b1, -7, 1'b1, 60);
    wait_result("after_reset");
  endtask

  task automatic test_back_to_back();
    sb.push_back(model(4, 40));
    pulse(1'b1, 4, 1'b1, 40);
    wait_result("b2b_4_40");
    sb.push_back(model(-128, 65535));
    pulse(1'b1, -128, 1'b1, 65535);
    wait_result("b2b_m128");
    sb.push_back(model(-256, 0));
    pulse(1'b1, -256, 1'b1, 0);
    wait_result("b2b_m256_clamp");
    tests++;
    if (sb.size() !== 0) begin
      $display("FAIL scoreboard leftover: got %0d want 0", sb.size()); fails++;
    end
  endtask

  initial begin
    rstn  = 1'b0;
    ex_v  = 1'b0;
    ex_d  = 9'd0;
    ex2_v = 1'b0;
    ex2_d = 16'd0;
    test_reset();
    test_split_strobes();
    test_simultaneous();
    test_order_overwrite();
    test_max_and_drop();
    test_reset_mid_sqrt();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
